// File: rtl/ft_lockstep_ctrl.sv
// Dual-core lockstep fault-tolerance controller: compares write ports, checkpoints clean state,
// and on mismatch replays the shadow register file and restores the PC. Optional: FT_ERR_COUNT_EN.
module ft_lockstep_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_WPORTS = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(32'h0000_0080)
) (
    input  logic                             clk_i,
    input  logic                             rst_n,
    input  logic [NUM_WPORTS-1:0]            we_a_i,
    input  logic [NUM_WPORTS-1:0]            we_b_i,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] addr_a_i,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] addr_b_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] data_a_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] data_b_i,
    input  logic                             pc_valid_i,
    input  logic [DATA_WIDTH-1:0]            spc_i,
    input  logic                             replay_ready_i,
    output logic                             replay_valid_o,
    output logic [ADDR_WIDTH-1:0]            replay_addr_o,
    output logic [DATA_WIDTH-1:0]            replay_data_o,
    output logic                             pc_restore_o,
    output logic [DATA_WIDTH-1:0]            spc_o,
    output logic                             fetch_block_o,
`ifdef FT_ERR_COUNT_EN
    output logic [15:0]                      err_count_o,
    output logic [NUM_WPORTS-1:0]            err_port_o,
`endif
    output logic                             error_o
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_REPLAY  = 2'd2;
    localparam logic [1:0] ST_RESTORE = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic [NUM_WPORTS-1:0] port_mismatch;
    logic                  commit;
    logic [DATA_WIDTH-1:0] shadow_rd;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];

    // Per-port lockstep comparison
    always_comb begin
        port_mismatch = '0;
        for (int p = 0; p < int'(NUM_WPORTS); p++) begin
            if (we_a_i[p] != we_b_i[p]) begin
                port_mismatch[p] = 1'b1;
            end else if (we_a_i[p] &&
                         ((addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH] != addr_b_i[p*ADDR_WIDTH +: ADDR_WIDTH]) ||
                          (data_a_i[p*DATA_WIDTH +: DATA_WIDTH] != data_b_i[p*DATA_WIDTH +: DATA_WIDTH]))) begin
                port_mismatch[p] = 1'b1;
            end
        end
    end

    assign error_o = (state == ST_RUN) && (|port_mismatch);
    assign commit  = (state == ST_RUN) && !error_o;

    // Next-state and next replay index
    always_comb begin
        next_state = state;
        next_idx   = replay_addr_o;
        case (state)
            ST_RUN: begin
                if (error_o) next_state = ST_HALT;
            end
            ST_HALT: begin
                next_state = ST_REPLAY;
                next_idx   = ADDR_WIDTH'(1);
            end
            ST_REPLAY: begin
                if (replay_ready_i) begin
                    if (replay_addr_o == LAST_IDX) next_state = ST_RESTORE;
                    else next_idx = replay_addr_o + ADDR_WIDTH'(1);
                end
            end
            ST_RESTORE: next_state = ST_RUN;
            default:    next_state = ST_RUN;
        endcase
    end

    assign shadow_rd = (32'(next_idx) < NUM_REGS) ? shadow[next_idx] : '0;

    // Outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            replay_valid_o <= 1'b0;
            replay_addr_o  <= '0;
            replay_data_o  <= '0;
            pc_restore_o   <= 1'b0;
            fetch_block_o  <= 1'b0;
        end else begin
            state          <= next_state;
            replay_valid_o <= (next_state == ST_REPLAY);
            replay_addr_o  <= next_idx;
            replay_data_o  <= (next_state == ST_REPLAY) ? shadow_rd : '0;
            pc_restore_o   <= (next_state == ST_RESTORE);
            fetch_block_o  <= (next_state != ST_RUN);
        end
    end

    // Checkpoint: later ports overwrite earlier ones on address collision
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) shadow[r] <= '0;
            spc_o <= RESET_PC;
        end else if (commit) begin
            for (int p = 0; p < int'(NUM_WPORTS); p++) begin
                if (we_a_i[p] && (addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                    (32'(addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH]) < NUM_REGS)) begin
                    shadow[addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= data_a_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (pc_valid_i) spc_o <= spc_i;
        end
    end

`ifdef FT_ERR_COUNT_EN
    // Saturating error statistics captured on each RUN->HALT transition
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_count_o <= '0;
            err_port_o  <= '0;
        end else if (error_o) begin
            if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            err_port_o <= port_mismatch;
        end
    end
`endif

endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Directed self-checking bench for ft_lockstep_ctrl (default 2 ports, 32 regs).
module tb_ft_lockstep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [63:0] data_a, data_b;
    logic        pc_valid;
    logic [31:0] spc_in;
    logic        replay_ready;
    logic        replay_valid;
    logic [4:0]  replay_addr;
    logic [31:0] replay_data;
    logic        pc_restore;
    logic [31:0] spc_out;
    logic        fetch_block;
    logic        error;
`ifdef FT_ERR_COUNT_EN
    logic [15:0] err_count;
    logic [1:0]  err_port;
`endif

    logic [31:0] model [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft_lockstep_ctrl dut (
        .clk_i          (clk),
        .rst_n          (rst_n),
        .we_a_i         (we_a),
        .we_b_i         (we_b),
        .addr_a_i       (addr_a),
        .addr_b_i       (addr_b),
        .data_a_i       (data_a),
        .data_b_i       (data_b),
        .pc_valid_i     (pc_valid),
        .spc_i          (spc_in),
        .replay_ready_i (replay_ready),
        .replay_valid_o (replay_valid),
        .replay_addr_o  (replay_addr),
        .replay_data_o  (replay_data),
        .pc_restore_o   (pc_restore),
        .spc_o          (spc_out),
        .fetch_block_o  (fetch_block),
`ifdef FT_ERR_COUNT_EN
        .err_count_o    (err_count),
        .err_port_o     (err_port),
`endif
        .error_o        (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = '0; we_b = '0; addr_a = '0; addr_b = '0;
        data_a = '0; data_b = '0; pc_valid = 1'b0; spc_in = '0;
    endtask

    // Identical write on one port of both cores
    task automatic same_write(input int p, input logic [4:0] a, input logic [31:0] d);
        we_a[p] = 1'b1; we_b[p] = 1'b1;
        addr_a[p*5 +: 5] = a; addr_b[p*5 +: 5] = a;
        data_a[p*32 +: 32] = d; data_b[p*32 +: 32] = d;
    endtask

    // Entered one cycle after the error edge (HALT). Returns early at abort_at.
    task automatic do_replay(input int stall_at, input int stall_n, input logic [31:0] exp_pc,
                             input int abort_at);
        int beats = 0;
        int stalls = 0;
        logic done;
        chk("halt_fetch_block", 32'(fetch_block), 1);
        chk("halt_valid", 32'(replay_valid), 0);
        tick();
        for (int e = 1; e < 32; e++) begin
            done = 1'b0;
            while (!done) begin
                if (e == abort_at) return;
                chk("beat_valid", 32'(replay_valid), 1);
                chk("beat_addr", 32'(replay_addr), 32'(e));
                chk("beat_data", replay_data, model[e]);
                chk("beat_fetch_block", 32'(fetch_block), 1);
                if (e == stall_at && stalls < stall_n) begin
                    replay_ready = 1'b0;
                    stalls++;
                end else begin
                    replay_ready = 1'b1;
                    done = 1'b1;
                end
                if (replay_valid && replay_ready) beats++;
                tick();
            end
        end
        replay_ready = 1'b0;
        chk("beat_count", 32'(beats), 31);
        chk("restore_pulse", 32'(pc_restore), 1);
        chk("restore_pc", spc_out, exp_pc);
        chk("restore_fetch_block", 32'(fetch_block), 1);
        chk("restore_valid", 32'(replay_valid), 0);
        tick();
        chk("run_restore_low", 32'(pc_restore), 0);
        chk("run_fetch_block", 32'(fetch_block), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        replay_ready = 1'b0;
        idle();
        for (int r = 0; r < 32; r++) model[r] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        chk("rst_spc", spc_out, 32'h80);
        chk("rst_fetch_block", 32'(fetch_block), 0);
        chk("rst_valid", 32'(replay_valid), 0);
        chk("rst_restore", 32'(pc_restore), 0);
        chk("rst_addr", 32'(replay_addr), 0);
        chk("rst_data", replay_data, 0);
        chk("rst_error", 32'(error), 0);

        // Enable mismatch on port0 (A writes x9); port1 cleanly writes x11 -- neither may commit
        idle();
        we_a = 2'b11; we_b = 2'b10;
        addr_a = {5'd11, 5'd9}; addr_b = {5'd11, 5'd9};
        data_a = {32'h0000_0ABC, 32'h0000_0055}; data_b = data_a;
        pc_valid = 1'b1; spc_in = 32'h300;
        #1;
        chk("en_mismatch_error", 32'(error), 1);
        chk("en_mismatch_fetch_low", 32'(fetch_block), 0);
        tick();
        chk("error_outside_run", 32'(error), 0);
`ifdef FT_ERR_COUNT_EN
        chk("err_count", 32'(err_count), 1);
        chk("err_port", 32'(err_port), 1);
`endif
        idle();
        do_replay(0, 0, 32'h80, 0);

        // Clean commits
        idle(); same_write(0, 5'd5, 32'hDEAD_BEEF); pc_valid = 1'b1; spc_in = 32'h100;
        #1; chk("clean_error", 32'(error), 0);
        tick(); model[5] = 32'hDEAD_BEEF;
        idle(); same_write(1, 5'd7, 32'h9);
        tick(); model[7] = 32'h9;
        idle(); same_write(0, 5'd3, 32'h111); same_write(1, 5'd3, 32'h222);
        tick(); model[3] = 32'h222;
        idle(); same_write(0, 5'd0, 32'hFFFF); same_write(1, 5'd31, 32'h3131_3131);
        tick(); model[31] = 32'h3131_3131;

        // Data mismatch on port1 x7; retiring PC must not be checkpointed
        idle(); same_write(1, 5'd7, 32'h1);
        data_b[63:32] = 32'h2;
        pc_valid = 1'b1; spc_in = 32'h200;
        #1;
        chk("data_mismatch_error", 32'(error), 1);
        chk("data_mismatch_fetch_low", 32'(fetch_block), 0);
        tick();
        idle();
        do_replay(4, 3, 32'h100, 0);

        // Address mismatch, then reset at replay addr 10
        idle(); same_write(0, 5'd1, 32'h5);
        addr_b[4:0] = 5'd2;
        #1;
        chk("addr_mismatch_error", 32'(error), 1);
        tick();
        idle();
        do_replay(0, 0, 32'h0, 10);
        chk("pre_abort_addr", 32'(replay_addr), 10);
        rst_n = 1'b0;
        replay_ready = 1'b0;
        #1;
        chk("abort_valid", 32'(replay_valid), 0);
        chk("abort_addr", 32'(replay_addr), 0);
        chk("abort_data", replay_data, 0);
        chk("abort_fetch_block", 32'(fetch_block), 0);
        chk("abort_restore", 32'(pc_restore), 0);
        chk("abort_spc", spc_out, 32'h80);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_restore", 32'(pc_restore), 0);
            chk("post_abort_fetch_block", 32'(fetch_block), 0);
        end
        we_a = 2'b01;
        #1;
        chk("post_abort_run_error", 32'(error), 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
